// File: rtl/lcd_show_char_if.sv
// Request, font ROM and byte-writer signals of the character renderer.
// slave = the renderer, master = its surroundings (controller, ROM, SPI writer).
interface lcd_show_char_if;
   logic        show_char_flag;
   logic [6:0]  ascii_num;
   logic [8:0]  start_x;
   logic [8:0]  start_y;
   logic        en_size;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic        wr_req;
   logic        wr_dc;
   logic [7:0]  wr_byte;
   logic        wr_done;
   logic        busy;
   logic        show_char_done;

   modport master (
      output show_char_flag, ascii_num, start_x, start_y, en_size, rom_data, wr_done,
      input  rom_addr, wr_req, wr_dc, wr_byte, busy, show_char_done
   );

   modport slave (
      input  show_char_flag, ascii_num, start_x, start_y, en_size, rom_data, wr_done,
      output rom_addr, wr_req, wr_dc, wr_byte, busy, show_char_done
   );
endinterface

// File: rtl/lcd_show_char.sv
// Renders one glyph: sets the LCD address window, then streams RGB565 pixels
// from the font ROM to the SPI byte writer, one byte per wr_req/wr_done handshake.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for show_char_flag; request latched on the flag
//   S_SETUP  | sending the 11 window bytes (2A xs xe, 2B ys ye, 2C)
//   S_FETCH  | two cycles: drive rom_addr, then capture the glyph row byte
//   S_PIX_HI | sending the high byte of the current pixel
//   S_PIX_LO | sending the low byte; advance column / row / finish
//   S_DONE   | one-cycle show_char_done pulse
module lcd_show_char #(
   parameter logic [15:0] FG_COLOR = 16'h0000,
   parameter logic [15:0] BG_COLOR = 16'hFFFF
) (
   input logic            sys_clk,
   input logic            sys_rst,
   lcd_show_char_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_FETCH,
      S_PIX_HI,
      S_PIX_LO,
      S_DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [6:0]  glyph;
   logic [8:0]  xs;
   logic [8:0]  ys;
   logic        size16;
   logic [3:0]  setup_idx;
   logic [3:0]  row;
   logic [2:0]  col;
   logic        fetch_ph;
   logic        req_sent;
   logic [7:0]  row_sr;

   logic        byte_ack;
   logic        last_col;
   logic        last_row;
   logic [8:0]  xe;
   logic [8:0]  ye;
   logic [11:0] row_base;
   logic [11:0] glyph_addr;
   logic [15:0] pix_color;
   logic        setup_dc;
   logic [7:0]  setup_byte;

   // A wr_done only counts once its wr_req has gone out, which drops same-cycle
   // and stray acknowledges without any per-state special casing.
   assign byte_ack   = req_sent & bus.wr_done;
   assign last_col   = (col == (size16 ? 3'd7 : 3'd5));
   assign last_row   = (row == (size16 ? 4'd15 : 4'd11));
   assign xe         = xs + (size16 ? 9'd7 : 9'd5);
   assign ye         = ys + (size16 ? 9'd15 : 9'd11);
   assign row_base   = size16 ? {1'b0, glyph, 4'b0000} : 12'd1520 + 12'(glyph) * 12'd12;
   assign glyph_addr = row_base + 12'(row);
   assign pix_color  = row_sr[7] ? FG_COLOR : BG_COLOR;

   always_comb begin
      setup_dc   = 1'b1;
      setup_byte = 8'h00;
      case (setup_idx)
         4'd0:    begin setup_dc = 1'b0; setup_byte = 8'h2A; end
         4'd1:    setup_byte = {7'd0, xs[8]};
         4'd2:    setup_byte = xs[7:0];
         4'd3:    setup_byte = {7'd0, xe[8]};
         4'd4:    setup_byte = xe[7:0];
         4'd5:    begin setup_dc = 1'b0; setup_byte = 8'h2B; end
         4'd6:    setup_byte = {7'd0, ys[8]};
         4'd7:    setup_byte = ys[7:0];
         4'd8:    setup_byte = {7'd0, ye[8]};
         4'd9:    setup_byte = ye[7:0];
         4'd10:   begin setup_dc = 1'b0; setup_byte = 8'h2C; end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt          = state;
      bus.wr_req         = 1'b0;
      bus.wr_dc          = 1'b0;
      bus.wr_byte        = 8'h00;
      bus.rom_addr       = 12'd0;
      bus.busy           = 1'b1;
      bus.show_char_done = 1'b0;
      case (state)
         S_IDLE: begin
            bus.busy = 1'b0;
            if (bus.show_char_flag) state_nxt = S_SETUP;
         end
         S_SETUP: begin
            bus.wr_req  = ~req_sent;
            bus.wr_dc   = setup_dc;
            bus.wr_byte = setup_byte;
            if (byte_ack && setup_idx == 4'd10) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            bus.rom_addr = glyph_addr;
            if (fetch_ph) state_nxt = S_PIX_HI;
         end
         S_PIX_HI: begin
            bus.wr_req  = ~req_sent;
            bus.wr_dc   = 1'b1;
            bus.wr_byte = pix_color[15:8];
            if (byte_ack) state_nxt = S_PIX_LO;
         end
         S_PIX_LO: begin
            bus.wr_req  = ~req_sent;
            bus.wr_dc   = 1'b1;
            bus.wr_byte = pix_color[7:0];
            if (byte_ack) begin
               if (!last_col)      state_nxt = S_PIX_HI;
               else if (!last_row) state_nxt = S_FETCH;
               else                state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            bus.show_char_done = 1'b1;
            state_nxt          = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= S_IDLE;
         glyph     <= 7'd0;
         xs        <= 9'd0;
         ys        <= 9'd0;
         size16    <= 1'b0;
         setup_idx <= 4'd0;
         row       <= 4'd0;
         col       <= 3'd0;
         fetch_ph  <= 1'b0;
         req_sent  <= 1'b0;
         row_sr    <= 8'd0;
      end else begin
         state <= state_nxt;
         if (bus.wr_req)    req_sent <= 1'b1;
         else if (byte_ack) req_sent <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.show_char_flag) begin
                  glyph     <= (bus.ascii_num > 7'd94) ? 7'd0 : bus.ascii_num;
                  xs        <= bus.start_x;
                  ys        <= bus.start_y;
                  size16    <= bus.en_size;
                  setup_idx <= 4'd0;
                  row       <= 4'd0;
                  col       <= 3'd0;
                  fetch_ph  <= 1'b0;
               end
            end
            S_SETUP: begin
               if (byte_ack) setup_idx <= setup_idx + 4'd1;
            end
            S_FETCH: begin
               fetch_ph <= ~fetch_ph;
               if (fetch_ph) row_sr <= bus.rom_data;
            end
            S_PIX_LO: begin
               if (byte_ack) begin
                  row_sr <= {row_sr[6:0], 1'b0};
                  if (last_col) begin
                     col <= 3'd0;
                     row <= row + 4'd1;
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/lcd_show_char.md
# lcd_show_char

Character renderer that sits directly downstream of the string/number controller. On each `show_char_flag` pulse it latches one character request (glyph index, position, font size) and sets the LCD column/row address window. It then fetches glyph rows from the font ROM and streams 16-bit RGB565 pixels as command/data bytes to the SPI byte writer. It pulses `show_char_done` when the character is complete.

## Interface
- `FG_COLOR`, 16'h0000, foreground pixel colour (RGB565).
- `BG_COLOR`, 16'hFFFF, background pixel colour (RGB565).
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `show_char_flag`  in  1  one-cycle start pulse; sampled only in IDLE.
- `ascii_num`  in  7  glyph index (ASCII-32), 0..94 valid.
- `start_x`  in  9  left pixel column.
- `start_y`  in  9  top pixel row.
- `en_size`  in  1  1 = 8x16 font, 0 = 6x12 font.
- `rom_addr`  out  12  font ROM byte address.
- `rom_data`  in  8  font ROM data; valid 1 cycle after `rom_addr`.
- `wr_req`  out  1  one-cycle pulse requesting one byte write.
- `wr_dc`  out  1  0 = command byte, 1 = data byte; stable from `wr_req` until `wr_done`.
- `wr_byte`  out  8  byte to send; stable from `wr_req` until `wr_done`.
- `wr_done`  in  1  one-cycle pulse: the writer finished the current byte.
- `busy`  out  1  high while a character is in progress.
- `show_char_done`  out  1  one-cycle completion pulse.

## Operation
- **Reset values:** all outputs are 0 (`rom_addr`, `wr_req`, `wr_dc`, `wr_byte`, `busy`, `show_char_done`); FSM = IDLE.
- **Latch in IDLE:** on `show_char_flag`, latch `ascii_num`, `start_x`, `start_y`, `en_size`. If `ascii_num` > 94, the latched value is 0 (space).
- **Font dimensions:**
  - size16: W = 8, H = 16.
  - size12: W = 6, H = 12.
  - xe = start_x + W - 1 and ye = start_y + H - 1, both 9-bit, zero-extended to 16 bits for transmission.
- **Setup sequence:** 11 bytes, in order:
  - cmd 0x2A, then data xs_hi, xs_lo, xe_hi, xe_lo;
  - cmd 0x2B, then data ys_hi, ys_lo, ye_hi, ye_lo;
  - cmd 0x2C.
- **ROM address:**
  - size16: `ascii_num`*16 + row.
  - size12: 1520 + `ascii_num`*12 + row.
- **Row bits:** one byte per glyph row; MSB is the leftmost pixel. size12 uses bits 7..2 only.
- **Pixel output:** pixels are sent row-major. Each pixel is 2 data bytes, hi then lo. Colour is `FG_COLOR` if the glyph bit is 1, else `BG_COLOR`.
- **Byte totals:** size16 = 11 + 256 = 267 bytes; size12 = 11 + 144 = 155 bytes.
- **FSM states:**
  - IDLE → SETUP on flag.
  - SETUP → FETCH after the 11th `wr_done`.
  - FETCH: drive `rom_addr`, wait 1 cycle, latch `rom_data` into the row shift register, then go to PIX_HI.
  - PIX_HI → PIX_LO on `wr_done`.
  - PIX_LO → PIX_HI (next column) on `wr_done`; after the last column → FETCH (next row); after the last row → DONE.
  - DONE → IDLE after 1 cycle.
- **Busy/done:** `busy` is high in every state except IDLE. `show_char_done` is high only in DONE.
- **Ignored inputs:**
  - `show_char_flag` outside IDLE (including the DONE cycle).
  - `wr_done` in IDLE, FETCH, DONE, or in the same cycle as `wr_req`.
- **Reset mid-character:** the FSM aborts to IDLE immediately and all outputs return to reset values. No `show_char_done` is produced.

## Timing
- **Start latency:** flag in cycle N → `busy` and first `wr_req` (0x2A, `wr_dc` = 0) in cycle N+1.
- **Next byte:** `wr_req` for the next byte comes the cycle after `wr_done`. The exception is a row boundary, which inserts 2 FETCH cycles (ROM address, then data latch) before `wr_req`.
- **First pixel:** the first pixel `wr_req` is 3 cycles after the 11th `wr_done`, since FETCH sits between setup and pixels.
- **Completion:** `show_char_done` is high in the cycle after the final `wr_done`. `busy` drops in the following cycle, when the FSM is back in IDLE.
- **Back-to-back:** a new flag is accepted 2 cycles after the final `wr_done`.
- **Writer stalls:** stalls of any length are tolerated; exactly one `wr_req` is issued per byte.

## Test plan
- **Size16 setup:** `ascii_num`=40, x=72, y=16, size16, writer `wr_done` 3 cycles after each `wr_req` → bytes 2A,00,48,00,4F,2B,00,10,00,1F,2C; first `rom_addr` = 640; 267 total `wr_req`; one `show_char_done`.
- **Size12 setup:** `ascii_num`=33, x=6, y=12, size12 → bytes 2A,00,06,00,0B,2B,00,0C,00,17,2C; `rom_addr` 1916..1927; 155 total bytes.
- **Pixel colours:** ROM row byte 0xA0, size16, default colours → first 4 pixels are FFFF? No: bit 1 → FG; pixel bytes 00,00,FF,FF,00,00,FF,FF.
- **Wide x / invalid glyph:** x=300 → setup bytes 01,2C,01,33 for the column window; `ascii_num`=100 → `rom_addr` uses index 0.
- **Flag while busy:** second `show_char_flag` mid-character is ignored; byte count and `show_char_done` count stay 1 per accepted flag.
- **Reset mid-character:** assert `sys_rst` after 50 bytes → outputs are 0 immediately, no `show_char_done`; a new flag then restarts cleanly at 0x2A.
